// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: 640x480@60 raster generator for the pixel draw path.
// Presents the current coordinate to the draw block. Takes its RGB565 answer
// DRAW_LATENCY cycles later and drives HS/VS/BLANK delayed so they line up
// with that colour at the DAC.
module vga_timing_ctrl #(
    parameter int   H_ACTIVE     = 640,
    parameter int   H_FP         = 16,
    parameter int   H_SYNC       = 96,
    parameter int   H_BP         = 48,
    parameter int   V_ACTIVE     = 480,
    parameter int   V_FP         = 10,
    parameter int   V_SYNC       = 2,
    parameter int   V_BP         = 33,
    parameter int   DRAW_LATENCY = 2,
    parameter logic SYNC_POL     = 1'b0
) (
    input  logic        iVGA_CLK,
    input  logic        iReset_n,
    input  logic [15:0] iRGB,
    output logic [9:0]  ovga_x,
    output logic [9:0]  ovga_y,
    output logic        oActive,
    output logic        oFrame_start,
    output logic        oVGA_HS,
    output logic        oVGA_VS,
    output logic        oVGA_BLANK_n,
    output logic        oVGA_SYNC_n,
    output logic [7:0]  oVGA_R,
    output logic [7:0]  oVGA_G,
    output logic [7:0]  oVGA_B
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Pipeline word {hs, vs, active}; idle = syncs deasserted, not visible
    localparam logic [2:0] L_IDLE = {~SYNC_POL, ~SYNC_POL, 1'b0};

    logic [9:0] r_h_cnt;
    logic [9:0] r_v_cnt;
    logic       w_hs_raw;
    logic       w_vs_raw;
    logic [2:0] w_raw;
    logic [2:0] w_dly;

    logic       r_hs;
    logic       r_vs;
    logic       r_blank_n;
    logic [7:0] r_r;
    logic [7:0] r_g;
    logic [7:0] r_b;

    // Raster counters: h wraps every line, v steps on the h wrap
    always_ff @(posedge iVGA_CLK or negedge iReset_n) begin
        if (!iReset_n) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 10'd1;
        end else begin
            r_h_cnt <= r_h_cnt + 10'd1;
        end
    end

    assign ovga_x       = r_h_cnt;
    assign ovga_y       = r_v_cnt;
    assign oActive      = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);
    assign oFrame_start = (r_h_cnt == '0) && (r_v_cnt == '0);

    assign w_hs_raw = ((r_h_cnt >= HS_FIRST) && (r_h_cnt <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
    assign w_vs_raw = ((r_v_cnt >= VS_FIRST) && (r_v_cnt <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
    assign w_raw    = {w_hs_raw, w_vs_raw, oActive};

    generate
        if (DRAW_LATENCY == 0) begin : g_nodly
            // Combinational draw path: output register samples the live timing
            assign w_dly = w_raw;
        end else begin : g_dly
            logic [DRAW_LATENCY-1:0][2:0] r_pipe;

            // Timing shift register matching the draw block's latency
            always_ff @(posedge iVGA_CLK or negedge iReset_n) begin
                if (!iReset_n) begin
                    r_pipe <= {DRAW_LATENCY{L_IDLE}};
                end else begin
                    r_pipe[0] <= w_raw;
                    for (int k = 1; k < DRAW_LATENCY; k++) begin
                        r_pipe[k] <= r_pipe[k-1];
                    end
                end
            end

            assign w_dly = r_pipe[DRAW_LATENCY-1];
        end
    endgenerate

    // Output register: syncs, blank and expanded colour captured together
    always_ff @(posedge iVGA_CLK or negedge iReset_n) begin
        if (!iReset_n) begin
            r_hs      <= ~SYNC_POL;
            r_vs      <= ~SYNC_POL;
            r_blank_n <= 1'b0;
            r_r       <= '0;
            r_g       <= '0;
            r_b       <= '0;
        end else begin
            r_hs      <= w_dly[2];
            r_vs      <= w_dly[1];
            r_blank_n <= w_dly[0];
            if (w_dly[0]) begin
                // MSB replication so full-scale 5/6-bit maps to 8'hFF
                r_r <= {iRGB[15:11], iRGB[15:13]};
                r_g <= {iRGB[10:5],  iRGB[10:9]};
                r_b <= {iRGB[4:0],   iRGB[4:2]};
            end else begin
                r_r <= '0;
                r_g <= '0;
                r_b <= '0;
            end
        end
    end

    assign oVGA_HS      = r_hs;
    assign oVGA_VS      = r_vs;
    assign oVGA_BLANK_n = r_blank_n;
    assign oVGA_SYNC_n  = 1'b0;
    assign oVGA_R       = r_r;
    assign oVGA_G       = r_g;
    assign oVGA_B       = r_b;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench for vga_timing_ctrl. Horizontal geometry is the real 640x480
// timing; the vertical geometry is shrunk (6 visible lines, 13 total) so two
// whole frames fit in a short run. VS still spans 2 lines = 1600 clocks.
module tb_vga_timing_ctrl;

    localparam int HA = 640, HF = 16, HSY = 96, HB = 48;
    localparam int VA = 6, VF = 2, VSY = 2, VB = 3;
    localparam int HT = 800;
    localparam int VT = 13;
    localparam int FRAME = 10400;
    localparam int LAT = 3;          // DRAW_LATENCY + 1

    logic        clk;
    logic        rstn;
    logic [15:0] rgb;
    logic [9:0]  vx, vy;
    logic        act, fs, hs, vs, bn, sn;
    logic [7:0]  r, g, b;

    vga_timing_ctrl #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
        .DRAW_LATENCY(2), .SYNC_POL(1'b0)
    ) dut (
        .iVGA_CLK(clk), .iReset_n(rstn), .iRGB(rgb),
        .ovga_x(vx), .ovga_y(vy), .oActive(act), .oFrame_start(fs),
        .oVGA_HS(hs), .oVGA_VS(vs), .oVGA_BLANK_n(bn), .oVGA_SYNC_n(sn),
        .oVGA_R(r), .oVGA_G(g), .oVGA_B(b)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    int nchk = 0;
    int nfail = 0;
    int k = 0;   // cycle index since reset release (cycle 0 holds coordinate 0)

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        k++;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_x"},  32'(vx), 0);
        chk({tag, "_y"},  32'(vy), 0);
        chk({tag, "_hs"}, 32'(hs), 1);
        chk({tag, "_vs"}, 32'(vs), 1);
        chk({tag, "_bn"}, 32'(bn), 0);
        chk({tag, "_rgb"}, {8'd0, r, g, b}, 0);
        chk({tag, "_sn"}, 32'(sn), 0);
        chk({tag, "_act"}, 32'(act), 1);
        chk({tag, "_fs"}, 32'(fs), 1);
    endtask

    // Expected {hs, vs, blank_n} at the pins in cycle kk
    function automatic logic [2:0] model_out(input int kk);
        int c, h, v;
        logic mh, mv, mb;
        if (kk < LAT) return 3'b110;
        c  = kk - LAT;
        h  = c % HT;
        v  = (c / HT) % VT;
        mh = !(h >= HA + HF && h < HA + HF + HSY);
        mv = !(v >= VA + VF && v < VA + VF + VSY);
        mb = (h < HA) && (v < VA);
        return {mh, mv, mb};
    endfunction

    initial begin
        int coord_bad, act_bad, fs_bad, hs_bad, vs_bad, bn_bad, rgb_bad;
        int t656, hs_run, vs_run, fs_hi, blank_l1, blank_l7;
        int hs_fall[$], hs_low[$], vs_fall[$], vs_low[$], fs_t[$];
        logic prev_hs, prev_vs;
        logic [2:0] m;
        logic [9:0] ex, ey, x1, x2, cur, col;
        logic [7:0] er;
        int align_bad, seen0, seen639, c;

        rgb  = 16'h0;
        rstn = 1'b0;

        // Power-on reset
        repeat (3) @(posedge clk);
        #1;
        chk_reset("por");
        rstn = 1'b1;
        k = 0;
        chk("rel_x0", 32'(vx), 0);
        step(); chk("rel_x1", 32'(vx), 1);
        step(); chk("rel_x2", 32'(vx), 2);
        step(); chk("rel_x3", 32'(vx), 3);

        // Reset in the middle of an HS pulse: must clear at once, no extension
        while (k < 700) step();
        chk("mid_x", 32'(vx), 700);
        chk("mid_hs_low", 32'(hs), 0);
        rgb  = 16'hFFFF;
        rstn = 1'b0;
        #1;
        chk_reset("async");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk_reset("hold");
        end
        rstn = 1'b1;
        k = 0;
        step(); chk("rst2_x1", 32'(vx), 1);
        step(); chk("rst2_x2", 32'(vx), 2);
        step(); chk("rst2_x3", 32'(vx), 3);

        // Two frames with constant white input: timing, sync and blanking
        coord_bad = 0; act_bad = 0; fs_bad = 0; hs_bad = 0; vs_bad = 0;
        bn_bad = 0; rgb_bad = 0; t656 = -1; hs_run = 0; vs_run = 0; fs_hi = 0;
        blank_l1 = 0; blank_l7 = 0; prev_hs = hs; prev_vs = vs;
        while (k < 2 * FRAME + 900) begin
            step();
            ex = 10'(k % HT);
            ey = 10'((k / HT) % VT);
            if (vx !== ex || vy !== ey) coord_bad++;
            if (act !== ((ex < 10'(HA)) && (ey < 10'(VA)))) act_bad++;
            if (fs !== ((ex == 10'd0) && (ey == 10'd0))) fs_bad++;
            m = model_out(k);
            if (hs !== m[2]) hs_bad++;
            if (vs !== m[1]) vs_bad++;
            if (bn !== m[0]) bn_bad++;
            er = m[0] ? 8'hFF : 8'h00;
            if (r !== er || g !== er || b !== er) rgb_bad++;
            if (vx == 10'd656 && t656 < 0) t656 = k;
            if (prev_hs && !hs) hs_fall.push_back(k);
            if (!hs) hs_run++;
            else if (!prev_hs) begin hs_low.push_back(hs_run); hs_run = 0; end
            if (prev_vs && !vs) vs_fall.push_back(k);
            if (!vs) vs_run++;
            else if (!prev_vs) begin vs_low.push_back(vs_run); vs_run = 0; end
            if (fs) begin fs_hi++; fs_t.push_back(k); end
            if (k >= LAT + HT && k < LAT + 2 * HT && !bn) blank_l1++;
            if (k >= LAT + 7 * HT && k < LAT + 8 * HT && !bn) blank_l7++;
            prev_hs = hs;
            prev_vs = vs;
        end
        chk("coord", 32'(coord_bad), 0);
        chk("active", 32'(act_bad), 0);
        chk("fs_model", 32'(fs_bad), 0);
        chk("hs_model", 32'(hs_bad), 0);
        chk("vs_model", 32'(vs_bad), 0);
        chk("bn_model", 32'(bn_bad), 0);
        chk("rgb_blank", 32'(rgb_bad), 0);
        chk("t656", 32'(t656), 656);
        chk("hs_first_lag", 32'(hs_fall[0] - t656), 3);
        chk("hs_width0", 32'(hs_low[0]), 96);
        chk("hs_width1", 32'(hs_low[1]), 96);
        chk("hs_period0", 32'(hs_fall[1] - hs_fall[0]), 800);
        chk("hs_period1", 32'(hs_fall[2] - hs_fall[1]), 800);
        chk("vs_first", 32'(vs_fall[0]), 6403);
        chk("vs_width", 32'(vs_low[0]), 1600);
        chk("vs_period", 32'(vs_fall[1] - vs_fall[0]), FRAME);
        chk("fs_first", 32'(fs_t[0]), FRAME);
        chk("fs_period", 32'(fs_t[1] - fs_t[0]), FRAME);
        chk("fs_width", 32'(fs_hi), 2);
        chk("blank_line", 32'(blank_l1), 160);
        chk("blank_vline", 32'(blank_l7), 800);

        // Colour expansion mid-line in the visible area
        rgb = 16'hF800; step(); chk("red", {8'd0, r, g, b}, 32'h00FF0000);
        rgb = 16'h8410; step(); chk("grey", {8'd0, r, g, b}, 32'h00848284);
        rgb = 16'h07E0; step(); chk("green", {8'd0, r, g, b}, 32'h0000FF00);
        rgb = 16'h001F; step(); chk("blue", {8'd0, r, g, b}, 32'h000000FF);
        rgb = 16'h0000; step(); chk("black", {8'd0, r, g, b}, 32'h00000000);
        chk("col_bn", 32'(bn), 1);

        // Alignment: draw block answers with its column in red, 2 cycles late
        align_bad = 0; seen0 = 0; seen639 = 0;
        x1 = vx; x2 = vx;
        for (int i = 0; i < 2 * HT + 10; i++) begin
            step();
            cur = vx;
            rgb = {x2[4:0], 11'd0};
            x2 = x1;
            x1 = cur;
            if (i >= 6) begin
                m = model_out(k);
                c = (k - LAT) % HT;
                col = 10'(c);
                if (m[0]) begin
                    er = {col[4:0], col[4:2]};
                    if (r !== er || g !== 8'd0 || b !== 8'd0 || bn !== 1'b1) align_bad++;
                    if (c == 0) seen0 = 1;
                    if (c == HA - 1) seen639 = 1;
                end else if (r !== 8'd0 || bn !== 1'b0) begin
                    align_bad++;
                end
            end
        end
        chk("align", 32'(align_bad), 0);
        chk("align_col0", 32'(seen0), 1);
        chk("align_col639", 32'(seen639), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
        $finish;
    end

endmodule
